// File: rtl/lagd_mem_bank_arbiter.sv
// lagd_mem_bank_arbiter
// Single-bank arbiter in front of one SRAM bank. One wide port with priority
// and NumNarrow round-robin narrow ports share the bank. After WidePriorityWait
// consecutive cycles of starving the narrow side, one narrow access is let through.
// Each access returns one rvalid on the port that issued it, BankAccessLatency
// cycles after its grant.
// Optional build macro: LAGD_MEM_ARB_PERF_EN enables the 32-bit conflict-cycle
// counter on perf_conflict_o. Without it, perf_conflict_o is tied to zero.
module lagd_mem_bank_arbiter #(
    parameter int unsigned NumNarrow         = 2,
    parameter int unsigned AddrWidth         = 11,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned WidePriorityWait  = 4,
    parameter int unsigned BankAccessLatency = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumNarrow-1:0]           narrow_req_i,
    input  logic [NumNarrow-1:0]           narrow_we_i,
    input  logic [NumNarrow*AddrWidth-1:0] narrow_addr_i,
    input  logic [NumNarrow*DataWidth-1:0] narrow_wdata_i,
    output logic [NumNarrow-1:0]           narrow_gnt_o,
    output logic [NumNarrow-1:0]           narrow_rvalid_o,
    output logic [DataWidth-1:0]           narrow_rdata_o,
    input  logic                           wide_req_i,
    input  logic                           wide_we_i,
    input  logic [AddrWidth-1:0]           wide_addr_i,
    input  logic [DataWidth-1:0]           wide_wdata_i,
    output logic                           wide_gnt_o,
    output logic                           wide_rvalid_o,
    output logic [DataWidth-1:0]           wide_rdata_o,
    output logic                           bank_req_o,
    output logic                           bank_we_o,
    output logic [AddrWidth-1:0]           bank_addr_o,
    output logic [DataWidth-1:0]           bank_wdata_o,
    input  logic [DataWidth-1:0]           bank_rdata_i,
    output logic [31:0]                    perf_conflict_o
);

    localparam int unsigned IdxW = (NumNarrow > 1) ? $clog2(NumNarrow) : 1;
    localparam int unsigned CntW = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
    localparam int unsigned Lat  = BankAccessLatency;

    logic [CntW-1:0] starve_cnt;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] rr_idx;
    logic            any_narrow;
    logic            narrow_wins;
    logic            wide_gnt;
    logic            narrow_gnt;

    logic [Lat-1:0]  pipe_valid;
    logic [Lat-1:0]  pipe_wide;
    logic [IdxW-1:0] pipe_idx [Lat];

    assign any_narrow = |narrow_req_i;

    // Narrow side wins when wide is idle or the starvation budget is used up.
    // Grants are held off while reset is asserted so outputs read zero.
    assign narrow_wins = any_narrow &&
                         (!wide_req_i ||
                          ((WidePriorityWait != 0) && (starve_cnt == CntW'(WidePriorityWait))));
    assign narrow_gnt  = rst_ni && narrow_wins;
    assign wide_gnt    = rst_ni && wide_req_i && !narrow_wins;

    assign narrow_gnt_o = narrow_gnt ? (NumNarrow'(1) << rr_idx) : '0;
    assign wide_gnt_o   = wide_gnt;
    assign bank_req_o   = wide_gnt | narrow_gnt;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
    always_comb begin
        logic            hit_hi;
        logic            hit_lo;
        logic [IdxW-1:0] idx_hi;
        logic [IdxW-1:0] idx_lo;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int unsigned j = 0; j < NumNarrow; j++) begin
            if (!hit_hi && narrow_req_i[j] && (j >= 32'(rr_ptr))) begin
                hit_hi = 1'b1;
                idx_hi = IdxW'(j);
            end
            if (!hit_lo && narrow_req_i[j]) begin
                hit_lo = 1'b1;
                idx_lo = IdxW'(j);
            end
        end
        rr_idx = hit_hi ? idx_hi : idx_lo;
    end

    // Route the granted port's operands to the bank.
    always_comb begin
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        if (wide_gnt) begin
            bank_we_o    = wide_we_i;
            bank_addr_o  = wide_addr_i;
            bank_wdata_o = wide_wdata_i;
        end else if (narrow_gnt) begin
            for (int unsigned j = 0; j < NumNarrow; j++) begin
                if (rr_idx == IdxW'(j)) begin
                    bank_we_o    = narrow_we_i[j];
                    bank_addr_o  = narrow_addr_i[j*AddrWidth +: AddrWidth];
                    bank_wdata_o = narrow_wdata_i[j*DataWidth +: DataWidth];
                end
            end
        end
    end

    // Count consecutive cycles in which a narrow request went unserved.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (narrow_gnt || !any_narrow) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CntW'(WidePriorityWait)) begin
            starve_cnt <= starve_cnt + CntW'(1);
        end
    end

    // Advance the round-robin pointer past the port just served.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (narrow_gnt) begin
            rr_ptr <= (rr_idx == IdxW'(NumNarrow - 1)) ? '0 : rr_idx + IdxW'(1);
        end
    end

    // Carry {valid, is_wide, index} of each granted access to the response slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_wide  <= '0;
            for (int unsigned i = 0; i < Lat; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= bank_req_o;
            pipe_wide[0]  <= wide_gnt;
            pipe_idx[0]   <= rr_idx;
            for (int unsigned i = 1; i < Lat; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_wide[i]  <= pipe_wide[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    assign wide_rvalid_o   = pipe_valid[Lat-1] && pipe_wide[Lat-1];
    assign narrow_rvalid_o = (pipe_valid[Lat-1] && !pipe_wide[Lat-1]) ?
                             (NumNarrow'(1) << pipe_idx[Lat-1]) : '0;
    // Read data is masked outside a response so the rdata outputs sit at zero.
    assign wide_rdata_o    = wide_rvalid_o ? bank_rdata_i : '0;
    assign narrow_rdata_o  = (|narrow_rvalid_o) ? bank_rdata_i : '0;

`ifdef LAGD_MEM_ARB_PERF_EN
    logic [31:0] perf_cnt;
    logic        conflict;

    assign conflict = (wide_req_i && !wide_gnt) || (|(narrow_req_i & ~narrow_gnt_o));

    // Count cycles where at least one request was left waiting; wraps at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt <= '0;
        end else if (conflict) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_conflict_o = perf_cnt;
`else
    assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_lagd_mem_bank_arbiter.sv
// Bench for lagd_mem_bank_arbiter. Two instances share one stimulus stream:
// instance 0 uses WidePriorityWait=4, latency 1; instance 1 uses
// WidePriorityWait=0, latency 3. A queue-free behavioural model (due-cycle
// slots) predicts grants, bank operands, responses and the conflict count.
module tb_lagd_mem_bank_arbiter;

    localparam int NN = 2;
    localparam int AW = 11;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic [NN-1:0]    n_req, n_we;
    logic [NN*AW-1:0] n_addr;
    logic [NN*DW-1:0] n_wdata;
    logic             w_req, w_we;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_wdata, b_rdata;

    logic [NN-1:0] o_ngnt [2];
    logic [NN-1:0] o_nrv  [2];
    logic [DW-1:0] o_nrd  [2];
    logic          o_wgnt [2];
    logic          o_wrv  [2];
    logic [DW-1:0] o_wrd  [2];
    logic          o_breq [2];
    logic          o_bwe  [2];
    logic [AW-1:0] o_baddr[2];
    logic [DW-1:0] o_bwd  [2];
    logic [31:0]   o_perf [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int          m_cnt [2];
    int          m_ptr [2];
    logic [31:0] m_perf[2];
    bit          exp_v [2][8];
    bit          exp_w [2][8];
    int          exp_i [2][8];
    bit          exp_we[2][8];

    always #5 clk = ~clk;

    lagd_mem_bank_arbiter #(.NumNarrow(NN), .AddrWidth(AW), .DataWidth(DW),
                            .WidePriorityWait(4), .BankAccessLatency(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .narrow_req_i(n_req), .narrow_we_i(n_we), .narrow_addr_i(n_addr), .narrow_wdata_i(n_wdata),
        .narrow_gnt_o(o_ngnt[0]), .narrow_rvalid_o(o_nrv[0]), .narrow_rdata_o(o_nrd[0]),
        .wide_req_i(w_req), .wide_we_i(w_we), .wide_addr_i(w_addr), .wide_wdata_i(w_wdata),
        .wide_gnt_o(o_wgnt[0]), .wide_rvalid_o(o_wrv[0]), .wide_rdata_o(o_wrd[0]),
        .bank_req_o(o_breq[0]), .bank_we_o(o_bwe[0]), .bank_addr_o(o_baddr[0]),
        .bank_wdata_o(o_bwd[0]), .bank_rdata_i(b_rdata), .perf_conflict_o(o_perf[0]));

    lagd_mem_bank_arbiter #(.NumNarrow(NN), .AddrWidth(AW), .DataWidth(DW),
                            .WidePriorityWait(0), .BankAccessLatency(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .narrow_req_i(n_req), .narrow_we_i(n_we), .narrow_addr_i(n_addr), .narrow_wdata_i(n_wdata),
        .narrow_gnt_o(o_ngnt[1]), .narrow_rvalid_o(o_nrv[1]), .narrow_rdata_o(o_nrd[1]),
        .wide_req_i(w_req), .wide_we_i(w_we), .wide_addr_i(w_addr), .wide_wdata_i(w_wdata),
        .wide_gnt_o(o_wgnt[1]), .wide_rvalid_o(o_wrv[1]), .wide_rdata_o(o_wrd[1]),
        .bank_req_o(o_breq[1]), .bank_we_o(o_bwe[1]), .bank_addr_o(o_baddr[1]),
        .bank_wdata_o(o_bwd[1]), .bank_rdata_i(b_rdata), .perf_conflict_o(o_perf[1]));

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s inst%0d cyc%0d got=%0h want=%0h", name, k, cyc, got, want);
        end
    endtask

    // Predict and compare one instance for the current cycle, then advance the model.
    task automatic model_step(input int k);
        int          wpw, lat, slot, ns, eg_n;
        bit          eg_w, n_any, conflict, g_we;
        logic [1:0]  eg_oh, exp_nrv;
        logic [31:0] exp_perf;
        wpw  = (k == 0) ? 4 : 0;
        lat  = (k == 0) ? 1 : 3;
        slot = cyc % 8;
        if (!rst_n) begin
            chk("rst_wgnt",  k, o_wgnt[k], 0);
            chk("rst_ngnt",  k, o_ngnt[k], 0);
            chk("rst_wrv",   k, o_wrv[k],  0);
            chk("rst_nrv",   k, o_nrv[k],  0);
            chk("rst_breq",  k, o_breq[k], 0);
            chk("rst_wrd",   k, o_wrd[k],  0);
            chk("rst_nrd",   k, o_nrd[k],  0);
            chk("rst_perf",  k, o_perf[k], 0);
            m_cnt[k]  = 0;
            m_ptr[k]  = 0;
            m_perf[k] = 0;
            for (int s = 0; s < 8; s++) exp_v[k][s] = 0;
            return;
        end
        n_any = (n_req != 0);
        eg_w  = 0;
        eg_n  = -1;
        if (w_req && (!n_any || wpw == 0 || m_cnt[k] < wpw)) begin
            eg_w = 1;
        end else if (n_any) begin
            for (int i = 0; i < NN; i++) begin
                if (eg_n < 0 && n_req[(m_ptr[k] + i) % NN]) eg_n = (m_ptr[k] + i) % NN;
            end
        end
        eg_oh = (eg_n >= 0) ? (2'b01 << eg_n) : 2'b00;
        chk("wide_gnt",   k, o_wgnt[k], eg_w);
        chk("narrow_gnt", k, o_ngnt[k], eg_oh);
        chk("bank_req",   k, o_breq[k], eg_w || eg_n >= 0);
        g_we = 0;
        if (eg_w) begin
            g_we = w_we;
            chk("bank_we",    k, o_bwe[k],   w_we);
            chk("bank_addr",  k, o_baddr[k], w_addr);
            chk("bank_wdata", k, o_bwd[k],   w_wdata);
        end else if (eg_n >= 0) begin
            g_we = n_we[eg_n];
            chk("bank_we",    k, o_bwe[k],   n_we[eg_n]);
            chk("bank_addr",  k, o_baddr[k], n_addr[eg_n*AW +: AW]);
            chk("bank_wdata", k, o_bwd[k],   n_wdata[eg_n*DW +: DW]);
        end
        exp_nrv = (exp_v[k][slot] && !exp_w[k][slot]) ? (2'b01 << exp_i[k][slot]) : 2'b00;
        chk("wide_rvalid",   k, o_wrv[k], exp_v[k][slot] && exp_w[k][slot]);
        chk("narrow_rvalid", k, o_nrv[k], exp_nrv);
        if (exp_v[k][slot] && !exp_we[k][slot]) begin
            if (exp_w[k][slot]) chk("wide_rdata", k, o_wrd[k], b_rdata);
            else                chk("narrow_rdata", k, o_nrd[k], b_rdata);
        end
        exp_v[k][slot] = 0;
`ifdef LAGD_MEM_ARB_PERF_EN
        exp_perf = m_perf[k];
`else
        exp_perf = 0;
`endif
        chk("perf", k, o_perf[k], exp_perf);
        conflict = (w_req && !eg_w) || ((n_req & ~eg_oh) != 0);
        if (conflict) m_perf[k] = m_perf[k] + 1;
        if (eg_n >= 0) begin
            m_cnt[k] = 0;
            m_ptr[k] = (eg_n + 1) % NN;
        end else if (n_any) begin
            m_cnt[k] = (m_cnt[k] + 1 > wpw) ? wpw : m_cnt[k] + 1;
        end else begin
            m_cnt[k] = 0;
        end
        if (eg_w || eg_n >= 0) begin
            ns = (cyc + lat) % 8;
            exp_v[k][ns]  = 1;
            exp_w[k][ns]  = eg_w;
            exp_i[k][ns]  = (eg_n >= 0) ? eg_n : 0;
            exp_we[k][ns] = g_we;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_req = '0; n_we = '0; n_addr = '0; n_wdata = '0;
        w_req = 1'b0; w_we = 1'b0; w_addr = '0; w_wdata = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [1:0]  t2_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [9:0]  t3_pat;
    logic [31:0] perf_want;

    initial begin
        rst_n = 1'b0;
        n_req = '0; n_we = '0; n_addr = '0; n_wdata = '0;
        w_req = 1'b0; w_we = 1'b0; w_addr = '0; w_wdata = '0;
        b_rdata = '0;
        repeat (3) @(posedge clk);

        // Wide-only read at 0x010, response one cycle later on instance 0.
        next_cycle();
        w_req = 1'b1; w_addr = 11'h010;
        settle();
        chk("t1_wgnt",  0, o_wgnt[0],  1);
        chk("t1_addr",  0, o_baddr[0], 11'h010);
        chk("t1_ngnt",  0, o_ngnt[0],  0);
        next_cycle();
        b_rdata = 64'hDEAD_BEEF_CAFE_0010;
        settle();
        chk("t1_wrv",  0, o_wrv[0], 1);
        chk("t1_wrd",  0, o_wrd[0], 64'hDEAD_BEEF_CAFE_0010);
        chk("t1_nrv",  0, o_nrv[0], 0);

        // Both narrow ports requesting: grants alternate 0,1,0,1.
        next_cycle();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i < 4) n_req = 2'b11;
            settle();
            if (i < 4) chk("t2_gnt", 0, o_ngnt[0], t2_seq[i]);
            if (i > 0) chk("t2_rv",  0, o_nrv[0],  t2_seq[i-1]);
        end

        // Wide and narrow 0 every cycle: instance 0 lets narrow in on the 5th and 10th.
        next_cycle();
        rst_n = 1'b0;
        t3_pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            w_req = 1'b1; n_req = 2'b01;
            settle();
            chk("t3_a_ngnt", 0, o_ngnt[0], t3_pat[i] ? 2'b01 : 2'b00);
            chk("t3_b_ngnt", 1, o_ngnt[1], 2'b00);
        end
        next_cycle();
        settle();
`ifdef LAGD_MEM_ARB_PERF_EN
        perf_want = 32'd10;
`else
        perf_want = 32'd0;
`endif
        chk("t3_perf", 0, o_perf[0], perf_want);
        chk("t3_perf", 1, o_perf[1], perf_want);

        // Latency 3 on instance 1: wide, n1, wide; reset drops the last response.
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        w_req = 1'b1; w_addr = 11'h020;
        settle();
        chk("t4_wgnt0", 1, o_wgnt[1], 1);
        next_cycle();
        n_req = 2'b10;
        settle();
        chk("t4_ngnt1", 1, o_ngnt[1], 2'b10);
        next_cycle();
        w_req = 1'b1;
        settle();
        next_cycle();
        settle();
        chk("t4_wrv3", 1, o_wrv[1], 1);
        chk("t4_nrv3", 1, o_nrv[1], 0);
        next_cycle();
        settle();
        chk("t4_nrv4", 1, o_nrv[1], 2'b10);
        chk("t4_wrv4", 1, o_wrv[1], 0);
        next_cycle();
        rst_n = 1'b0;
        settle();
        chk("t4_wrv5", 1, o_wrv[1], 0);

        // Randomized traffic with occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            if ($urandom_range(0, 99) < 2) rst_n = 1'b0;
            w_req   = ($urandom_range(0, 9) < 6);
            w_we    = 1'($urandom_range(0, 1));
            w_addr  = 11'($urandom);
            w_wdata = {$urandom, $urandom};
            n_req   = 2'($urandom);
            n_we    = 2'($urandom);
            n_addr  = 22'($urandom);
            n_wdata = {$urandom, $urandom, $urandom, $urandom};
            b_rdata = {$urandom, $urandom};
        end
        next_cycle();
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
